// File: rtl/tohost_exit_monitor.sv
// tohost doorbell decoder, console FIFO and run-exit status for the harness.
// Optional `define TOHOST_TRACE_EN prints decoded doorbell traffic.
module tohost_exit_monitor #(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000),
    parameter int unsigned CONS_DEPTH  = 4,
    parameter int unsigned EXIT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_data,
    input  logic [7:0]        req_mask,
    output logic              cons_valid,
    input  logic              cons_ready,
    output logic [7:0]        cons_data,
    output logic              io_success,
    output logic              io_failure,
    output logic [EXIT_W-1:0] exit_code,
    output logic [15:0]       ignored_count
);

    localparam int unsigned PW = (CONS_DEPTH > 1) ? $clog2(CONS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fail_q, fail_d;
    logic [EXIT_W-1:0] code_q, code_d;
    logic [15:0]       ign_q, ign_d;
    logic [7:0]        mem_q [CONS_DEPTH];

    logic        full, empty, acc, is_th, full_mask;
    logic        push, pop, ign_inc, exit_ev;
    logic [7:0]  dev, cmd;
    logic [47:0] pl;

    assign dev = req_data[63:56];
    assign cmd = req_data[55:48];
    assign pl  = req_data[47:0];

    assign full      = (cnt_q == CW'(CONS_DEPTH));
    assign empty     = (cnt_q == '0);
    assign req_ready = !((state_q == RUN) && full);
    assign acc       = req_valid && req_ready;
    assign is_th     = (req_addr == TOHOST_ADDR);
    assign full_mask = (req_mask == 8'hFF);

    assign cons_valid    = !empty;
    assign cons_data     = mem_q[rptr_q];
    assign io_success    = (state_q == DONE) && !fail_q;
    assign io_failure    = (state_q == DONE) && fail_q;
    assign exit_code     = code_q;
    assign ignored_count = ign_q;

    // Decode the doorbell, advance the FIFO and the RUN/DRAIN/DONE machine.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fail_d  = fail_q;
        code_d  = code_q;
        push    = 1'b0;
        ign_inc = 1'b0;
        exit_ev = 1'b0;
        pop     = cons_valid && cons_ready;

        if (acc && is_th) begin
            if (state_q == RUN) begin
                if (!full_mask) begin
                    ign_inc = 1'b1;
                end else if (req_data == 64'd0) begin
                    ign_inc = 1'b0;
                end else if (dev == 8'd0 && pl[0]) begin
                    exit_ev = 1'b1;
                    code_d  = EXIT_W'(pl[47:1]);
                    fail_d  = (pl[47:1] != '0);
                end else if (dev == 8'd0) begin
                    exit_ev = 1'b1;
                    code_d  = '1;
                    fail_d  = 1'b1;
                end else if (dev == 8'd1 && cmd == 8'd1) begin
                    push = 1'b1;
                end else begin
                    ign_inc = 1'b1;
                end
            end else if (req_data != 64'd0) begin
                ign_inc = 1'b1;
            end
        end

        if (push) wptr_d = wptr_q + PW'(1);
        if (pop)  rptr_d = rptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        ign_d = (ign_inc && ign_q != 16'hFFFF) ? ign_q + 16'd1 : ign_q;

        unique case (state_q)
            RUN:     if (exit_ev) state_d = (cnt_d == '0) ? DONE : DRAIN;
            DRAIN:   if (empty)   state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    // State, pointers and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            code_q  <= '0;
            ign_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            ign_q   <= ign_d;
        end
    end

    // Character storage; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= pl[7:0];
    end

`ifdef TOHOST_TRACE_EN
    // Trace every full doorbell write and the final exit.
    always @(posedge clk) begin
        if (!reset && acc && is_th && full_mask)
            $display("tohost: dev=%h cmd=%h pl=%h", dev, cmd, pl);
        if (!reset && state_q != DONE && state_d == DONE)
            $display("tohost: exit %0d", code_d);
    end
`endif

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Directed and randomized checks of tohost_exit_monitor against a queue model.
module tb_tohost_exit_monitor;

    localparam logic [31:0] TH = 32'h8000_1000;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_mask;
    logic        cons_valid;
    logic        cons_ready;
    logic [7:0]  cons_data;
    logic        io_success;
    logic        io_failure;
    logic [31:0] exit_code;
    logic [15:0] ignored_count;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: phase 0 running, 1 draining, 2 finished
    byte unsigned mq[$];
    int           m_phase;
    bit           m_fail;
    logic [31:0]  m_code;
    int           m_ign;

    tohost_exit_monitor dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .cons_valid(cons_valid), .cons_ready(cons_ready),
        .cons_data(cons_data),
        .io_success(io_success), .io_failure(io_failure),
        .exit_code(exit_code), .ignored_count(ignored_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_phase = 0;
        m_fail  = 1'b0;
        m_code  = '0;
        m_ign   = 0;
    endtask

    function automatic bit m_ready();
        return !(m_phase == 0 && mq.size() == DEPTH);
    endfunction

    task automatic model_step();
        logic [47:0] pl;
        logic [46:0] c47;
        bit acc, pop;
        int nxt;
        pl  = req_data[47:0];
        c47 = pl[47:1];
        acc = req_valid && m_ready();
        pop = (mq.size() > 0) && cons_ready;
        nxt = m_phase;
        if (m_phase == 1 && mq.size() == 0) nxt = 2;
        if (pop) void'(mq.pop_front());
        if (acc && req_addr == TH) begin
            if (m_phase == 0) begin
                if (req_mask != 8'hFF) m_ign++;
                else if (req_data == 64'd0) begin end
                else if (req_data[63:56] == 0 && pl[0]) begin
                    m_code = c47[31:0];
                    m_fail = (c47 != 0);
                    nxt = (mq.size() == 0) ? 2 : 1;
                end else if (req_data[63:56] == 0) begin
                    m_code = 32'hFFFF_FFFF;
                    m_fail = 1'b1;
                    nxt = (mq.size() == 0) ? 2 : 1;
                end else if (req_data[63:48] == 16'h0101)
                    mq.push_back(req_data[7:0]);
                else m_ign++;
            end else if (req_data != 64'd0) m_ign++;
        end
        if (m_ign > 65535) m_ign = 65535;
        m_phase = nxt;
    endtask

    // one clock: advance the model with the applied inputs, then the DUT
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_mask = 8'hFF;
        cons_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] m);
        req_valid = 1'b1;
        req_addr = a;
        req_data = d;
        req_mask = m;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({io_success, io_failure, cons_valid, req_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0001",
                     {io_success, io_failure, cons_valid, req_ready});
        end
        n_cmp++;
        if (exit_code !== 32'd0 || ignored_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_regs got code=%h ign=%h want 0/0",
                     exit_code, ignored_count);
        end
    endtask

    task automatic test_exit_success();
        do_reset();
        wr(TH, 64'h1, 8'hFF);
        n_cmp++;
        if ({io_success, io_failure} !== 2'b10 || exit_code !== 32'd0) begin
            n_bad++;
            $display("FAIL exit0 got s=%b f=%b code=%h want 1 0 0",
                     io_success, io_failure, exit_code);
        end
        cyc();
        cyc();
        n_cmp++;
        if (io_success !== 1'b1) begin
            n_bad++;
            $display("FAIL exit0_hold got %b want 1", io_success);
        end
        wr(TH, 64'h0, 8'hFF);
        n_cmp++;
        if (ignored_count !== 16'd0) begin
            n_bad++;
            $display("FAIL done_clear got %0d want 0", ignored_count);
        end
        wr(TH, 64'h1, 8'hFF);
        n_cmp++;
        if (ignored_count !== 16'd1) begin
            n_bad++;
            $display("FAIL done_ignored got %0d want 1", ignored_count);
        end
    endtask

    task automatic test_exit_fail();
        do_reset();
        wr(TH, 64'h7, 8'hFF);
        n_cmp++;
        if ({io_success, io_failure} !== 2'b01 || exit_code !== 32'd3) begin
            n_bad++;
            $display("FAIL exit3 got s=%b f=%b code=%h want 0 1 3",
                     io_success, io_failure, exit_code);
        end
        do_reset();
        wr(TH, 64'h0000_0002_0000_0001, 8'hFF);
        n_cmp++;
        if ({io_success, io_failure} !== 2'b01 || exit_code !== 32'd0) begin
            n_bad++;
            $display("FAIL exit_trunc got s=%b f=%b code=%h want 0 1 0",
                     io_success, io_failure, exit_code);
        end
    endtask

    task automatic test_drain();
        do_reset();
        wr(TH, 64'h0101_0000_0000_0048, 8'hFF);
        wr(TH, 64'h0101_0000_0000_0069, 8'hFF);
        wr(TH, 64'h1, 8'hFF);
        n_cmp++;
        if (io_success !== 1'b0 || cons_valid !== 1'b1 ||
            cons_data !== 8'h48) begin
            n_bad++;
            $display("FAIL drain_hold got s=%b v=%b d=%h want 0 1 48",
                     io_success, cons_valid, cons_data);
        end
        cons_ready = 1'b1;
        cyc();
        n_cmp++;
        if (cons_data !== 8'h69 || io_success !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_2nd got d=%h s=%b want 69 0",
                     cons_data, io_success);
        end
        cyc();
        n_cmp++;
        if (cons_valid !== 1'b0 || io_success !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty got v=%b s=%b want 0 0",
                     cons_valid, io_success);
        end
        cyc();
        n_cmp++;
        if (io_success !== 1'b1 || io_failure !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_done got s=%b f=%b want 1 0",
                     io_success, io_failure);
        end
    endtask

    task automatic test_fifo_full();
        byte unsigned exp;
        do_reset();
        for (int i = 0; i < 4; i++)
            wr(TH, {16'h0101, 40'h0, 8'(8'h61 + i)}, 8'hFF);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready got %b want 0", req_ready);
        end
        req_valid = 1'b1;
        req_data = {16'h0101, 40'h0, 8'h65};
        cyc();
        cons_ready = 1'b1;
        cyc();
        n_cmp++;
        if (req_ready !== 1'b1 || cons_data !== 8'h62) begin
            n_bad++;
            $display("FAIL full_pop got r=%b d=%h want 1 62",
                     req_ready, cons_data);
        end
        cons_ready = 1'b0;
        cyc();
        req_valid = 1'b0;
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'(8'h62 + i);
            n_cmp++;
            if (cons_valid !== 1'b1 || cons_data !== exp) begin
                n_bad++;
                $display("FAIL full_order%0d got v=%b d=%h want 1 %h",
                         i, cons_valid, cons_data, exp);
            end
            cyc();
        end
        n_cmp++;
        if (cons_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL full_end got %b want 0", cons_valid);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        wr(TH, 64'h1, 8'h0F);
        wr(TH, 64'h0200_0000_0000_0001, 8'hFF);
        wr(TH + 32'd8, 64'h1, 8'hFF);
        n_cmp++;
        if (ignored_count !== 16'd2 || io_success !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored got ign=%0d s=%b want 2 0",
                     ignored_count, io_success);
        end
        wr(TH, 64'h1000, 8'hFF);
        n_cmp++;
        if ({io_success, io_failure} !== 2'b01 ||
            exit_code !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL syscall got s=%b f=%b code=%h want 0 1 ffffffff",
                     io_success, io_failure, exit_code);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        wr(TH, 64'h0101_0000_0000_0041, 8'hFF);
        wr(TH, 64'h0101_0000_0000_0042, 8'hFF);
        wr(TH, 64'h5, 8'hFF);
        wr(TH, 64'h0300_0000_0000_0000, 8'hFF);
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({io_success, io_failure, cons_valid} !== 3'b000 ||
            exit_code !== 32'd0 || ignored_count !== 16'd0) begin
            n_bad++;
            $display("FAIL async_rst got s=%b f=%b v=%b code=%h ign=%0d",
                     io_success, io_failure, cons_valid, exit_code,
                     ignored_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        wr(TH, 64'h1, 8'hFF);
        n_cmp++;
        if ({io_success, io_failure, cons_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL post_rst_exit got s=%b f=%b v=%b want 1 0 0",
                     io_success, io_failure, cons_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        wr(TH, 64'h1, 8'hFF);
        req_valid = 1'b1;
        req_data = 64'h0400_0000_0000_0000;
        repeat (65540) cyc();
        req_valid = 1'b0;
        n_cmp++;
        if (ignored_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL saturate got %h want ffff", ignored_count);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [46:0] c;
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 199) == 0 ||
                (m_phase == 2 && $urandom_range(0, 19) == 0)) begin
                do_reset();
                continue;
            end
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr = ($urandom_range(0, 9) < 7) ? TH : $urandom;
            req_mask = ($urandom_range(0, 9) < 8) ? 8'hFF : 8'($urandom);
            cons_ready = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            c = {15'($urandom_range(0, 1)), 32'($urandom_range(0, 3))};
            case (sel)
                0, 1, 2, 3: req_data = {16'h0101, 40'h0, 8'($urandom)};
                4: req_data = 64'h0;
                5: req_data = ($urandom_range(0, 9) == 0) ?
                              {16'h0, c, 1'b1} : 64'h0102_0000_0000_0001;
                6: req_data = ($urandom_range(0, 9) == 0) ?
                              {16'h0, 47'($urandom) | 47'h2, 1'b0} :
                              64'h0001_0000_0000_0000;
                7: req_data = {$urandom, $urandom};
                default: req_data = {8'h0, 8'($urandom), 48'h0};
            endcase
            cyc();
            n_cmp++;
            if (req_ready !== m_ready() ||
                cons_valid !== (mq.size() > 0) ||
                (mq.size() > 0 && cons_data !== mq[0])) begin
                n_bad++;
                $display("FAIL rnd_fifo it=%0d got r=%b v=%b d=%h want %b %0d",
                         it, req_ready, cons_valid, cons_data, m_ready(),
                         mq.size());
            end
            n_cmp++;
            if (io_success !== (m_phase == 2 && !m_fail) ||
                io_failure !== (m_phase == 2 && m_fail) ||
                exit_code !== m_code ||
                ignored_count !== 16'(m_ign)) begin
                n_bad++;
                $display("FAIL rnd_stat it=%0d got s=%b f=%b code=%h ign=%0d want ph=%0d fl=%b code=%h ign=%0d",
                         it, io_success, io_failure, exit_code,
                         ignored_count, m_phase, m_fail, m_code, m_ign);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;
        req_mask = '0;
        cons_ready = 1'b0;
        model_clear();
        test_reset();
        test_exit_success();
        test_exit_fail();
        test_drain();
        test_fifo_full();
        test_ignored();
        test_reset_mid_drain();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
